// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package trap_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Synchronous exception cause codes
    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_LAF     = 5;
    localparam int unsigned CAUSE_SAF     = 7;
    localparam int unsigned CAUSE_ECALL_M = 11;

    // CSR write/set/clear modes
    localparam logic [1:0] WSC_READ  = 2'b00;
    localparam logic [1:0] WSC_WRITE = 2'b01;
    localparam logic [1:0] WSC_SET   = 2'b10;
    localparam logic [1:0] WSC_CLEAR = 2'b11;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // Hold counter and interrupt index widths
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-instruction port bundle between the pipeline and the trap controller.
interface trap_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            csr_rw_in;
    logic [1:0]      csr_wsc_mode_in;
    logic            csr_w_imm_mux;
    logic [11:0]     csr_rw_addr_in;
    logic [XLEN-1:0] csr_w_data_reg;
    logic [4:0]      csr_w_data_imm;
    logic [XLEN-1:0] csr_r_data_out;

    modport master (
        output csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
        input  csr_r_data_out
    );

    modport slave (
        input  csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
        output csr_r_data_out
    );
endinterface

// File: rtl/trap_csr_file.sv
// M-mode trap CSR storage: read mux, write/set/clear updates, trap and mret field updates.
// TRAP_VECTORED_EN: makes mtvec[1:0] writable (vectored mode select).
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int unsigned    XLEN           = 32,
    parameter int unsigned    N_IRQ          = 4,
    parameter int unsigned    IRQ_CAUSE_BASE = 16,
    parameter logic [XLEN-1:0] MTVEC_RESET   = '0
) (
    input  logic             clk,
    input  logic             rst,
    trap_ctrl_if.slave       bus,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_trap,
    input  logic [XLEN-1:0]  i_trap_cause,
    input  logic [XLEN-1:0]  i_trap_epc,
    input  logic [XLEN-1:0]  i_trap_tval,
    input  logic             i_mret,
    output logic             o_mstatus_mie,
    output logic [N_IRQ-1:0] o_mie,
    output logic [XLEN-1:0]  o_mtvec,
    output logic [XLEN-1:0]  o_mepc
);

`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = '1;
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif

    logic             r_mst_mie;
    logic             r_mst_mpie;
    logic [N_IRQ-1:0] r_mie;
    logic [XLEN-1:0]  r_mtvec;
    logic [XLEN-1:0]  r_mscratch;
    logic [XLEN-1:0]  r_mepc;
    logic [XLEN-1:0]  r_mcause;
    logic [XLEN-1:0]  r_mtval;

    logic [XLEN-1:0]  w_mstatus;
    logic [XLEN-1:0]  w_rdata;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_new;
    logic             w_we;

    // Place one bit per interrupt line at its cause-code position
    function automatic logic [XLEN-1:0] irq_layout(input logic [N_IRQ-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < N_IRQ; i++) r[IRQ_CAUSE_BASE + i] = v[i];
        return r;
    endfunction

    // Inverse of irq_layout for mie writes
    function automatic logic [N_IRQ-1:0] irq_extract(input logic [XLEN-1:0] v);
        logic [N_IRQ-1:0] r;
        r = '0;
        for (int i = 0; i < N_IRQ; i++) r[i] = v[IRQ_CAUSE_BASE + i];
        return r;
    endfunction

    // Read mux (pre-write values); MPP is hard-wired to machine mode
    always_comb begin
        w_mstatus                   = '0;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mst_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mst_mpie;
        w_mstatus[12:11]            = 2'b11;
        case (bus.csr_rw_addr_in)
            CSR_MSTATUS:  w_rdata = w_mstatus;
            CSR_MIE:      w_rdata = irq_layout(r_mie);
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MIP:      w_rdata = irq_layout(i_irq);
            default:      w_rdata = '0;
        endcase
    end

    // Write/set/clear value computed from the current read value
    always_comb begin
        w_wdata = bus.csr_w_imm_mux ? XLEN'(bus.csr_w_data_imm) : bus.csr_w_data_reg;
        case (bus.csr_wsc_mode_in)
            WSC_WRITE: w_new = w_wdata;
            WSC_SET:   w_new = w_rdata | w_wdata;
            WSC_CLEAR: w_new = w_rdata & ~w_wdata;
            default:   w_new = w_rdata;
        endcase
        w_we = bus.csr_rw_in && (bus.csr_wsc_mode_in != WSC_READ) && !i_trap;
    end

    // CSR registers; a trap overrides any CSR write, mret overrides mstatus writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET & MTVEC_MASK;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (i_trap) begin
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
            r_mepc     <= i_trap_epc & ~XLEN'(3);
            r_mcause   <= i_trap_cause;
            r_mtval    <= i_trap_tval;
        end else begin
            if (w_we) begin
                case (bus.csr_rw_addr_in)
                    CSR_MSTATUS: begin
                        r_mst_mie  <= w_new[MSTATUS_MIE_BIT];
                        r_mst_mpie <= w_new[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:      r_mie      <= irq_extract(w_new);
                    CSR_MTVEC:    r_mtvec    <= w_new & MTVEC_MASK;
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    CSR_MTVAL:    r_mtval    <= w_new;
                    default: ;
                endcase
            end
            if (i_mret) begin
                r_mst_mie  <= r_mst_mpie;
                r_mst_mpie <= 1'b1;
            end
        end
    end

    assign bus.csr_r_data_out = w_rdata;
    assign o_mstatus_mie      = r_mst_mie;
    assign o_mie              = r_mie;
    assign o_mtvec            = r_mtvec;
    assign o_mepc             = r_mepc;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt priority, redirect/flush, post-trap HOLD window.
// TRAP_VECTORED_EN: interrupts redirect to mtvec base + 4*cause when mtvec[1:0]==01.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     N_IRQ          = 4,
    parameter int unsigned     IRQ_CAUSE_BASE = 16,
    parameter int unsigned     HOLD_CYCLES    = 3,
    parameter logic [XLEN-1:0] MTVEC_RESET    = '0
) (
    input  logic             clk,
    input  logic             rst,
    trap_ctrl_if.slave       csr_bus,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             illegal_inst,
    input  logic             ecall_m,
    input  logic             l_access_fault,
    input  logic             s_access_fault,
    input  logic [XLEN-1:0]  fault_addr,
    input  logic             mret,
    input  logic [XLEN-1:0]  epc_cur,
    input  logic [XLEN-1:0]  epc_next,
    input  logic             epc_valid,
    output logic [XLEN-1:0]  PC_redirect,
    output logic             redirect_mux,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic             reg_EM_flush,
    output logic             reg_MW_flush,
    output logic             RegWrite_cancel,
    output logic             trap_busy
);

    trap_state_e      r_state;
    trap_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_mstatus_mie;
    logic [N_IRQ-1:0] w_mie;
    logic [XLEN-1:0]  w_mtvec;
    logic [XLEN-1:0]  w_mepc;

    logic             w_exc;
    logic [XLEN-1:0]  w_exc_cause;
    logic [XLEN-1:0]  w_exc_tval;
    logic [N_IRQ-1:0] w_irq_pend;
    logic             w_irq_hit;
    logic [IDX_W-1:0] w_irq_idx;
    logic [XLEN-2:0]  w_irq_code;
    logic             w_irq_take;
    logic             w_trap;
    logic             w_mret_take;
    logic [XLEN-1:0]  w_trap_cause;
    logic [XLEN-1:0]  w_trap_epc;
    logic [XLEN-1:0]  w_trap_tval;
    logic [XLEN-1:0]  w_trap_target;

    trap_csr_file #(
        .XLEN           (XLEN),
        .N_IRQ          (N_IRQ),
        .IRQ_CAUSE_BASE (IRQ_CAUSE_BASE),
        .MTVEC_RESET    (MTVEC_RESET)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .bus           (csr_bus),
        .i_irq         (irq_in),
        .i_trap        (w_trap),
        .i_trap_cause  (w_trap_cause),
        .i_trap_epc    (w_trap_epc),
        .i_trap_tval   (w_trap_tval),
        .i_mret        (w_mret_take),
        .o_mstatus_mie (w_mstatus_mie),
        .o_mie         (w_mie),
        .o_mtvec       (w_mtvec),
        .o_mepc        (w_mepc)
    );

    // Synchronous exception priority: illegal > ecall > load fault > store fault
    always_comb begin
        w_exc       = 1'b0;
        w_exc_cause = '0;
        w_exc_tval  = '0;
        if (epc_valid) begin
            if (illegal_inst) begin
                w_exc       = 1'b1;
                w_exc_cause = XLEN'(CAUSE_ILLEGAL);
            end else if (ecall_m) begin
                w_exc       = 1'b1;
                w_exc_cause = XLEN'(CAUSE_ECALL_M);
            end else if (l_access_fault) begin
                w_exc       = 1'b1;
                w_exc_cause = XLEN'(CAUSE_LAF);
                w_exc_tval  = fault_addr;
            end else if (s_access_fault) begin
                w_exc       = 1'b1;
                w_exc_cause = XLEN'(CAUSE_SAF);
                w_exc_tval  = fault_addr;
            end
        end
    end

    // Lowest-index enabled interrupt; mret in flight defers interrupts to after HOLD
    always_comb begin
        w_irq_pend = irq_in & w_mie & {N_IRQ{w_mstatus_mie}};
        w_irq_hit  = 1'b0;
        w_irq_idx  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_irq_pend[i]) begin
                w_irq_hit = 1'b1;
                w_irq_idx = IDX_W'(i);
            end
        end
        w_irq_code  = (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(w_irq_idx);
        w_irq_take  = w_irq_hit && epc_valid && (r_state == IDLE) && !w_exc && !mret;
        w_trap      = w_exc || w_irq_take;
        w_mret_take = mret && !w_exc;
    end

    // Trap payload and vector target
    always_comb begin
        w_trap_cause  = w_exc ? w_exc_cause : {1'b1, w_irq_code};
        w_trap_epc    = w_exc ? epc_cur : epc_next;
        w_trap_tval   = w_exc ? w_exc_tval : '0;
        w_trap_target = w_mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
        if (!w_exc && (w_mtvec[1:0] == 2'b01))
            w_trap_target = (w_mtvec & ~XLEN'(3)) + (XLEN'(w_irq_code) << 2);
`endif
    end

    // HOLD state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, redirect and flush outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        redirect_mux    = 1'b0;
        PC_redirect     = '0;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        RegWrite_cancel = 1'b0;

        if (w_trap) begin
            redirect_mux    = 1'b1;
            PC_redirect     = w_trap_target;
            reg_FD_flush    = 1'b1;
            reg_DE_flush    = 1'b1;
            reg_EM_flush    = 1'b1;
            reg_MW_flush    = 1'b1;
            RegWrite_cancel = 1'b1;
        end else if (w_mret_take) begin
            redirect_mux = 1'b1;
            PC_redirect  = w_mepc;
            reg_FD_flush = 1'b1;
            reg_DE_flush = 1'b1;
            reg_EM_flush = 1'b1;
        end

        if (w_trap || w_mret_take) begin
            if (HOLD_CYCLES == 0) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = CNT_W'(HOLD_CYCLES);
            end
        end else if (r_state == HOLD) begin
            if (r_cnt <= CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    assign trap_busy = (r_state == HOLD);

endmodule
